// File: rtl/present_inv_sbox_layer_serial_pkg.sv
// Shared definitions for the nibble-serial masked PRESENT inverse S-box layer:
// nibble count, controller state encoding and the plain inverse S-box table.
package present_pkg;

   localparam int NIBBLES = 16;
   localparam int NIB_W   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Unmasked inverse S-box, indexed 0..F. Not used by the datapath, which
   // computes the function in ANF form on shares; kept for models and checks.
   localparam logic [3:0] INV_SBOX [NIBBLES] = '{
      4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
      4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
   };

endpackage

// File: rtl/present_inv_sbox_layer_serial_anf.sv
// Two-share GHPC-style masked PRESENT inverse S-box, LAT register stages,
// no reset. Share 1 is expanded into all 16 candidate results (one per
// possible value of share 0), each re-masked with fresh r and registered;
// a later stage selects the candidate with share 0. Output share 0 is the
// registered fresh mask itself, so the two output shares recombine to
// InvS(in0 ^ in1) without the unmasked value ever existing on a wire.
module present_inv_sbox_ANF
   import present_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic       clk,
   input  logic [3:0] r,
   input  logic [3:0] in0,
   input  logic [3:0] in1,
   output logic [3:0] out0,
   output logic [3:0] out1
);

   // Inverse S-box in algebraic normal form (a = x[0] .. d = x[3]).
   function automatic logic [3:0] inv_anf(input logic [3:0] x);
      logic a, b, c, d;
      logic [3:0] y;
      a = x[0];
      b = x[1];
      c = x[2];
      d = x[3];
      y[0] = 1'b1 ^ a ^ c ^ (b & d);
      y[1] = a ^ b ^ d ^ (a & c) ^ (b & d) ^ (c & d)
           ^ (a & b & c) ^ (a & b & d) ^ (a & c & d);
      y[2] = 1'b1 ^ d ^ (a & b) ^ (a & c) ^ (b & c) ^ (a & d) ^ (b & d)
           ^ (a & b & c) ^ (a & b & d) ^ (a & c & d);
      y[3] = a ^ b ^ c ^ d ^ (a & b) ^ (a & b & c) ^ (a & c & d);
      return y;
   endfunction

   logic [3:0] cand [NIBBLES];

   // Candidate results for every hypothesis on share 0, each masked with r.
   always_comb begin
      for (int v = 0; v < NIBBLES; v++) begin
         cand[v] = inv_anf(4'(v) ^ in1) ^ r;
      end
   end

   if (LAT == 1) begin : g_one
      logic [3:0] o0_q;
      logic [3:0] o1_q;

      // Single stage: select and register in the same cycle.
      always_ff @(posedge clk) begin
         o0_q <= r;
         o1_q <= cand[in0];
      end

      assign out0 = o0_q;
      assign out1 = o1_q;
   end else begin : g_multi
      logic [3:0] cand_q [NIBBLES];
      logic [3:0] x0_q;
      logic [3:0] m_q;
      logic [3:0] sh0_q [LAT-1];
      logic [3:0] sh1_q [LAT-1];

      // Stage 1: register candidates, share 0 and the mask separately.
      always_ff @(posedge clk) begin
         cand_q <= cand;
         x0_q   <= in0;
         m_q    <= r;
      end

      // Stage 2: share-0 select, then any extra delay stages up to LAT.
      always_ff @(posedge clk) begin
         sh0_q[0] <= m_q;
         sh1_q[0] <= cand_q[x0_q];
         for (int s = 1; s < LAT - 1; s++) begin
            sh0_q[s] <= sh0_q[s-1];
            sh1_q[s] <= sh1_q[s-1];
         end
      end

      assign out0 = sh0_q[LAT-2];
      assign out1 = sh1_q[LAT-2];
   end

endmodule

// File: rtl/present_inv_sbox_layer_serial.sv
// Nibble-serial masked PRESENT inverse S-box layer. A 64-bit two-share state
// is captured on start, its nibbles are fed LSB first through one pipelined
// masked gadget, and results are written back in place. done pulses once the
// full layer result sits in out0/out1.
//
// state | meaning
// IDLE  | waiting for start; out0/out1 hold the last result
// FEED  | presenting nibble feed_cnt to the gadget, one per cycle
// DRAIN | gadget input idle, waiting for the last write-back
// DONE  | one-cycle completion pulse
module present_inv_sbox_layer_serial
   import present_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] in0,
   input  logic [63:0] in1,
   input  logic [63:0] r,
   output logic        busy,
   output logic        done,
   output logic [63:0] out0,
   output logic [63:0] out1
);

   state_e          state_q, state_d;
   logic [3:0]      feed_cnt_q, feed_cnt_d;
   logic [4:0]      wb_cnt_q, wb_cnt_d;
   logic [LAT-1:0]  vld_q, vld_d;
   logic [63:0]     st0_q, st0_d;
   logic [63:0]     st1_q, st1_d;

   logic            feed_vld;
   logic            wb_fire;
   logic [3:0]      g_in0, g_in1, g_r;
   logic [3:0]      g_out0, g_out1;

   assign feed_vld = (state_q == FEED);
   assign wb_fire  = vld_q[LAT-1];

   // Each share is sliced on its own; the gadget is the only place they meet.
   assign g_in0 = st0_q[NIB_W*feed_cnt_q +: NIB_W];
   assign g_in1 = st1_q[NIB_W*feed_cnt_q +: NIB_W];
   assign g_r   = r[NIB_W*feed_cnt_q +: NIB_W];

   present_inv_sbox_ANF #(
      .LAT (LAT)
   ) u_gadget (
      .clk  (clk),
      .r    (g_r),
      .in0  (g_in0),
      .in1  (g_in1),
      .out0 (g_out0),
      .out1 (g_out1)
   );

   // Valid bit tracks each fed nibble through the gadget's LAT stages.
   always_comb begin
      vld_d    = vld_q << 1;
      vld_d[0] = feed_vld;
   end

   // Next state and counters. DRAIN leaves in the cycle the 16th write-back
   // lands so that done follows the last write directly.
   always_comb begin
      state_d    = state_q;
      feed_cnt_d = feed_cnt_q;
      wb_cnt_d   = wb_cnt_q;
      if (wb_fire) begin
         wb_cnt_d = wb_cnt_q + 5'd1;
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               feed_cnt_d = '0;
               wb_cnt_d   = '0;
               state_d    = FEED;
            end
         end
         FEED: begin
            if (feed_cnt_q == 4'(NIBBLES - 1)) begin
               state_d = DRAIN;
            end else begin
               feed_cnt_d = feed_cnt_q + 4'd1;
            end
         end
         DRAIN: begin
            if (wb_cnt_d == 5'(NIBBLES)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers: capture on accepted start, in-place nibble write-back.
   always_comb begin
      st0_d = st0_q;
      st1_d = st1_q;
      if (state_q == IDLE && start) begin
         st0_d = in0;
         st1_d = in1;
      end else if (wb_fire) begin
         st0_d[NIB_W*wb_cnt_q[3:0] +: NIB_W] = g_out0;
         st1_d[NIB_W*wb_cnt_q[3:0] +: NIB_W] = g_out1;
      end
   end

   // Sequential state; reset discards any in-flight nibbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         feed_cnt_q <= '0;
         wb_cnt_q   <= '0;
         vld_q      <= '0;
         st0_q      <= '0;
         st1_q      <= '0;
      end else begin
         state_q    <= state_d;
         feed_cnt_q <= feed_cnt_d;
         wb_cnt_q   <= wb_cnt_d;
         vld_q      <= vld_d;
         st0_q      <= st0_d;
         st1_q      <= st1_d;
      end
   end

   assign busy = (state_q == FEED) || (state_q == DRAIN);
   assign done = (state_q == DONE);
   assign out0 = st0_q;
   assign out1 = st1_q;

endmodule
